envelope_mu_modulator: RTL
==========================

Name: envelope_mu_modulator

Overview:
Downstream consumer of the per-oscillator O-U amplitude envelopes (Q14, nominal 0.5–1.5). On each 4 kHz clk_en tick it snapshots NUM_CH envelope/MU_DT pairs. It computes mu_eff = (mu_dt * envelope) >>> FRAC per channel through one time-shared 2-stage multiplier pipeline. Each result is clamped and, optionally, slew-limited, then written to a registered output bank that feeds the oscillator cores.

Parameters:
- WIDTH, 18, sample width (signed).
- FRAC, 14, fractional bits (Q14).
- NUM_CH, 4, number of oscillator channels (2..16).
- MU_MAX, 18'sd16384, upper clamp for mu_eff.
- SLEW_MAX, 18'sd64, max |change| of mu_eff per update (used only with slew feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- clk_en  in  1  4 kHz update strobe, one clk wide.
- envelope_flat  in  NUM_CH*WIDTH  packed signed Q14 envelopes; channel i at [i*WIDTH +: WIDTH].
- mu_dt_flat  in  NUM_CH*WIDTH  packed signed Q14 base MU_DT per channel.
- mu_eff_flat  out  NUM_CH*WIDTH  packed modulated MU_DT, registered.
- busy  out  1  high while a sweep is in progress (states LOAD, RUN, FLUSH).
- done  out  1  one-clk pulse when all channels have been written for the sweep.
- sat  out  1  one-clk pulse, high if any channel clamped during the sweep; asserted with done.

Behaviour:
- Reset (async): state=IDLE; mu_eff_flat=0; busy=0; done=0; sat=0; ch counter=0; primed=0; pipeline valid bits=0.
- FSM:
  - IDLE: if clk_en, snapshot both input buses into internal registers, ch=0, go LOAD.
  - LOAD: one cycle; go RUN.
  - RUN: each clk, issue channel ch into stage 1 (signed product, 2*WIDTH bits, registered, valid1=1). ch increments; when ch==NUM_CH-1 is issued, go FLUSH.
  - FLUSH: stay until stage 2 has written the last channel; then assert done (and sat if any clamp occurred), go IDLE.
- Stage 2, one clk after stage 1:
  - Arithmetic shift right by FRAC, truncated to WIDTH.
  - Clamp: <0 → 0; >MU_MAX → MU_MAX. Any clamp sets sticky sweep_sat.
  - Write mu_eff[ch].
- Latency: the clk_en sampling edge is edge 0. Channel k is written at edge k+3. done is high in the cycle following edge NUM_CH+2. Total sweep is NUM_CH+3 clk; it must be ≪ the clk_en period.
- Snapshot isolation: input changes after edge 0 do not affect the current sweep.
- clk_en while busy or in the done cycle: ignored, no queueing. No output changes outside stage-2 writes.
- mu_eff_flat holds its value between sweeps. Each channel changes only at its own write edge, so channels update staggered.
- sweep_sat is cleared at edge 0 of each sweep.
- Reset mid-sweep: immediate return to reset values; a partial sweep is discarded.

Optional Feature:
- Macro ENV_MOD_SLEW_EN.
- Defined: stage 2 computes delta = clamped − mu_eff[ch], limits it to [−SLEW_MAX, +SLEW_MAX], and writes mu_eff[ch] + limited delta.
  - The first sweep after reset (primed=0) bypasses slew and writes the clamped value directly; primed is set at that sweep's done.
  - Slew limiting does not set sat.
- Undefined: the clamped value is written directly; the primed register is absent.

Test Plan:
- Reset, then clk_en with mu_dt=4096 and envelope=16384 on all channels → every mu_eff=4096, done at 6 clk after the sampling edge (NUM_CH=4), sat=0.
- Ch0 mu_dt=4096, env=24576; ch1 env=8192 → ch0=6144, ch1=2048. With ENV_MOD_SLEW_EN after priming at 4096: ch0=4160, ch1=4032 on the next sweep.
- Ch2 mu_dt=−100, env=16384 → ch2=0 and the sat pulse coincides with done. Ch3 mu_dt=16384, env=24576 → ch3=16384 (MU_MAX), sat=1.
- Pulse clk_en again 2 clk into a sweep → ignored. Exactly one done; outputs match the first snapshot. Toggling inputs mid-sweep has no effect.
- Assert rst at RUN cycle 2 → mu_eff=0, busy=0, done never fires. The next clk_en runs a full sweep; with slew, it is unlimited (primed cleared).
- Envelope sweep 8192→24576 ramped over 100 clk_en with mu_dt=8192 → outputs track 4096..12288 ±1 LSB (no slew). Channel written-order check: 0,1,2,3 on consecutive edges.

Source files
------------

// File: rtl/envelope_mu_modulator.sv
// envelope_mu_modulator
//
// Purpose: scales each channel's base MU_DT by its O-U amplitude envelope.
// On each clk_en tick both input buses are snapshotted and every channel is
// processed through one shared two-stage pipeline. Stage 1 registers the
// signed product. Stage 2 shifts it back to Q14, clamps it to [0, MU_MAX]
// and writes the registered output bank. Channels are written one per clock.
//
// Optional feature (macro ENV_MOD_SLEW_EN): stage 2 limits each output step
// to +/-SLEW_MAX. The first sweep after reset is written unlimited.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   clk_en          4 kHz update strobe (one clk wide)
//   envelope_flat   packed signed Q14 envelopes, channel i at [i*WIDTH +: WIDTH]
//   mu_dt_flat      packed signed Q14 base MU_DT per channel
//   mu_eff_flat     packed modulated MU_DT, registered
//   busy            high while a sweep is in progress
//   done            one-clk pulse once the last channel has been written
//   sat             one-clk pulse with done if any channel clamped
module envelope_mu_modulator #(
    parameter int                      WIDTH    = 18,
    parameter int                      FRAC     = 14,
    parameter int                      NUM_CH   = 4,
    parameter logic signed [WIDTH-1:0] MU_MAX   = 18'sd16384,
    parameter logic signed [WIDTH-1:0] SLEW_MAX = 18'sd64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic [NUM_CH*WIDTH-1:0] envelope_flat,
    input  logic [NUM_CH*WIDTH-1:0] mu_dt_flat,
    output logic [NUM_CH*WIDTH-1:0] mu_eff_flat,
    output logic                    busy,
    output logic                    done,
    output logic                    sat
);

    localparam int             CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [CH_W-1:0]              ch_q, ch_d;
    logic [NUM_CH*WIDTH-1:0]      env_snap_q, env_snap_d;
    logic [NUM_CH*WIDTH-1:0]      mu_snap_q, mu_snap_d;
    logic signed [2*WIDTH-1:0]    prod_q, prod_d;
    logic                         valid1_q, valid1_d;
    logic [CH_W-1:0]              ch1_q, ch1_d;
    logic signed [WIDTH-1:0]      mu_eff_q [NUM_CH];
    logic signed [WIDTH-1:0]      mu_eff_d [NUM_CH];
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         sat_q, sat_d;
    logic                         sweep_sat_q, sweep_sat_d;

    logic signed [WIDTH-1:0]      env_ch_s;
    logic signed [WIDTH-1:0]      mu_ch_s;
    logic signed [WIDTH-1:0]      trunc_s;
    logic signed [WIDTH-1:0]      clamped_s;
    logic                         clamp_hit_s;
    logic signed [WIDTH-1:0]      cur_s;
    logic signed [WIDTH-1:0]      wr_val_s;

    // Snapshot operands for the channel being issued into stage 1.
    assign env_ch_s = env_snap_q[int'(ch_q)*WIDTH +: WIDTH];
    assign mu_ch_s  = mu_snap_q[int'(ch_q)*WIDTH +: WIDTH];

    // Current output of the channel sitting in stage 2.
    assign cur_s    = mu_eff_q[ch1_q];

    // Stage 2 arithmetic: Q14 rescale (truncated to WIDTH) then clamp to [0, MU_MAX].
    always_comb begin
        trunc_s     = WIDTH'(prod_q >>> FRAC);
        clamped_s   = trunc_s;
        clamp_hit_s = 1'b0;
        if (trunc_s < $signed({WIDTH{1'b0}})) begin
            clamped_s   = {WIDTH{1'b0}};
            clamp_hit_s = 1'b1;
        end else if (trunc_s > MU_MAX) begin
            clamped_s   = MU_MAX;
            clamp_hit_s = 1'b1;
        end else begin
            clamped_s   = trunc_s;
            clamp_hit_s = 1'b0;
        end
    end

`ifdef ENV_MOD_SLEW_EN
    localparam logic signed [WIDTH:0] SLEW_P = (WIDTH+1)'(SLEW_MAX);
    localparam logic signed [WIDTH:0] SLEW_N = -SLEW_P;

    logic                    primed_q, primed_d;
    logic signed [WIDTH:0]   cur_ext_s;
    logic signed [WIDTH:0]   delta_s;
    logic signed [WIDTH:0]   limited_s;

    // Slew limit: step towards the clamped target by at most SLEW_MAX.
    // The result always lies between cur and target, so it fits WIDTH bits.
    always_comb begin
        cur_ext_s = (WIDTH+1)'(cur_s);
        delta_s   = (WIDTH+1)'(clamped_s) - cur_ext_s;
        if (delta_s > SLEW_P) begin
            limited_s = SLEW_P;
        end else if (delta_s < SLEW_N) begin
            limited_s = SLEW_N;
        end else begin
            limited_s = delta_s;
        end
        if (primed_q) begin
            wr_val_s = WIDTH'(cur_ext_s + limited_s);
        end else begin
            wr_val_s = clamped_s;
        end
    end
`else
    // Without slew limiting the clamped value is written as is.
    always_comb begin
        wr_val_s = clamped_s;
    end
`endif

    // Next-state logic: sweep FSM, stage-1 issue and stage-2 bank write.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        env_snap_d  = env_snap_q;
        mu_snap_d   = mu_snap_q;
        prod_d      = prod_q;
        valid1_d    = 1'b0;
        ch1_d       = ch1_q;
        mu_eff_d    = mu_eff_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sat_d       = 1'b0;
        sweep_sat_d = sweep_sat_q;
`ifdef ENV_MOD_SLEW_EN
        primed_d    = primed_q;
`endif

        // Stage 2 write happens whenever stage 1 holds a valid product.
        if (valid1_q) begin
            mu_eff_d[ch1_q] = wr_val_s;
            sweep_sat_d     = sweep_sat_q | clamp_hit_s;
        end else begin
            sweep_sat_d     = sweep_sat_q;
        end

        case (state_q)
            S_IDLE: begin
                // A strobe landing in the done cycle is dropped, not queued.
                if (clk_en && !done_q) begin
                    env_snap_d  = envelope_flat;
                    mu_snap_d   = mu_dt_flat;
                    ch_d        = {CH_W{1'b0}};
                    sweep_sat_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_LOAD;
                end else begin
                    state_d     = S_IDLE;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                prod_d   = (2*WIDTH)'(env_ch_s) * (2*WIDTH)'(mu_ch_s);
                valid1_d = 1'b1;
                ch1_d    = ch_q;
                if (ch_q == LAST_CH) begin
                    state_d = S_FLUSH;
                end else begin
                    ch_d    = ch_q + {{(CH_W-1){1'b0}}, 1'b1};
                end
            end
            S_FLUSH: begin
                // Finish on the edge that writes the last channel.
                if (valid1_q && (ch1_q == LAST_CH)) begin
                    done_d  = 1'b1;
                    sat_d   = sweep_sat_q | clamp_hit_s;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
`ifdef ENV_MOD_SLEW_EN
                    primed_d = 1'b1;
`endif
                end else begin
                    state_d = S_FLUSH;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and pipeline registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ch_q        <= {CH_W{1'b0}};
            env_snap_q  <= {(NUM_CH*WIDTH){1'b0}};
            mu_snap_q   <= {(NUM_CH*WIDTH){1'b0}};
            prod_q      <= {(2*WIDTH){1'b0}};
            valid1_q    <= 1'b0;
            ch1_q       <= {CH_W{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                mu_eff_q[i] <= {WIDTH{1'b0}};
            end
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sat_q       <= 1'b0;
            sweep_sat_q <= 1'b0;
`ifdef ENV_MOD_SLEW_EN
            primed_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            env_snap_q  <= env_snap_d;
            mu_snap_q   <= mu_snap_d;
            prod_q      <= prod_d;
            valid1_q    <= valid1_d;
            ch1_q       <= ch1_d;
            mu_eff_q    <= mu_eff_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sat_q       <= sat_d;
            sweep_sat_q <= sweep_sat_d;
`ifdef ENV_MOD_SLEW_EN
            primed_q    <= primed_d;
`endif
        end
    end

    // Output bank packing.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign mu_eff_flat[g*WIDTH +: WIDTH] = mu_eff_q[g];
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sat  = sat_q;

endmodule
